// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button event classifier: channel state
// encoding, event bit ordering used when packing into MMIO registers.
package button_event_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } state_t;

    // Bit positions of each event when a channel's pulses are packed together.
    typedef enum int {
        EV_PRESS   = 0,
        EV_RELEASE = 1,
        EV_LONG    = 2,
        EV_REPEAT  = 3
    } event_idx_t;

    localparam int NUM_EVENTS = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_channel.sv
// One button channel: edge detection, IDLE/SHORT/LONG hold FSM and
// registered one-cycle event pulses.
module button_event_channel
    import button_event_gen_pkg::*;
#(
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200,
    parameter int HOLD_CNT_WIDTH = $clog2(max_int(LONG_TICKS, REPEAT_TICKS)) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic tick,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [HOLD_CNT_WIDTH-1:0] LONG_LAST   = HOLD_CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [HOLD_CNT_WIDTH-1:0] REPEAT_LAST = HOLD_CNT_WIDTH'(REPEAT_TICKS - 1);
    localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_ONE    = HOLD_CNT_WIDTH'(1);

    state_t                    state;
    state_t                    next_state;
    logic                      prev;
    logic [HOLD_CNT_WIDTH-1:0] hold_cnt;
    logic [HOLD_CNT_WIDTH-1:0] next_hold_cnt;
    logic [NUM_EVENTS-1:0]     events;
    logic [NUM_EVENTS-1:0]     next_events;
    logic                      held_q;
    logic                      rise;
    logic                      fall;

    assign rise = sig & ~prev;
    assign fall = ~sig & prev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prev     <= 1'b0;
            hold_cnt <= '0;
            events   <= '0;
            held_q   <= 1'b0;
        end else begin
            state    <= next_state;
            prev     <= sig;
            hold_cnt <= next_hold_cnt;
            events   <= next_events;
            held_q   <= (next_state != IDLE);
        end
    end

    // A fall always takes priority over a coincident tick.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        next_state    = state;
        next_hold_cnt = hold_cnt;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    next_state    = SHORT;
                    next_hold_cnt = '0;
                end
            end
            SHORT: begin
                if (fall) begin
                    next_state    = IDLE;
                    next_hold_cnt = '0;
                end else if (tick) begin
                    if (hold_cnt == LONG_LAST) begin
                        next_state    = LONG;
                        next_hold_cnt = '0;
                    end else begin
                        next_hold_cnt = hold_cnt + HOLD_ONE;
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    next_state    = IDLE;
                    next_hold_cnt = '0;
                end else if (tick) begin
                    if (hold_cnt == REPEAT_LAST) next_hold_cnt = '0;
                    else                         next_hold_cnt = hold_cnt + HOLD_ONE;
                end
            end
            default: begin
                next_state    = IDLE;
                next_hold_cnt = '0;
            end
        endcase
    end

    always_comb begin
        next_events = '0;
        unique case (state)
            IDLE: next_events[EV_PRESS] = rise;
            SHORT: begin
                if (fall)                               next_events[EV_RELEASE] = 1'b1;
                else if (tick && hold_cnt == LONG_LAST) next_events[EV_LONG]    = 1'b1;
            end
            LONG: begin
                if (fall)                                 next_events[EV_RELEASE] = 1'b1;
                else if (tick && hold_cnt == REPEAT_LAST) next_events[EV_REPEAT]  = 1'b1;
            end
            default: next_events = '0;
        endcase
    end

    assign press_pulse   = events[EV_PRESS];
    assign release_pulse = events[EV_RELEASE];
    assign long_pulse    = events[EV_LONG];
    assign repeat_pulse  = events[EV_REPEAT];
    assign held          = held_q;

endmodule

// File: rtl/button_event_gen.sv
// Button event generator: shared hold-timing prescaler feeding WIDTH
// independent press/release/long/repeat channels.
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int TICK_CNT_MAX   = 62500,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200,
    parameter int TICK_CNT_WIDTH = $clog2(TICK_CNT_MAX),
    parameter int HOLD_CNT_WIDTH = $clog2(max_int(LONG_TICKS, REPEAT_TICKS)) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] held
);

    localparam logic [TICK_CNT_WIDTH-1:0] TICK_LAST = TICK_CNT_WIDTH'(TICK_CNT_MAX - 1);
    localparam logic [TICK_CNT_WIDTH-1:0] TICK_ONE  = TICK_CNT_WIDTH'(1);

    logic [TICK_CNT_WIDTH-1:0] tick_cnt;
    logic                      tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TICK_ONE;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_channel
        button_event_channel #(
            .LONG_TICKS     (LONG_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS),
            .HOLD_CNT_WIDTH (HOLD_CNT_WIDTH)
        ) u_channel (
            .clk           (clk),
            .rst           (rst),
            .sig           (debounced_signal[i]),
            .tick          (tick),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i]),
            .held          (held[i])
        );
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: behavioural model counting whole ticks since
// each press, directed scenarios with literal timing expectations, random soak.
module tb_button_event_gen;

    localparam int WIDTH        = 2;
    localparam int TICK_CNT_MAX = 4;
    localparam int LONG_TICKS   = 3;
    localparam int REPEAT_TICKS = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] debounced_signal;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic [WIDTH-1:0] long_pulse;
    logic [WIDTH-1:0] repeat_pulse;
    logic [WIDTH-1:0] held;

    button_event_gen #(
        .WIDTH        (WIDTH),
        .TICK_CNT_MAX (TICK_CNT_MAX),
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .debounced_signal (debounced_signal),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_pulse       (long_pulse),
        .repeat_pulse     (repeat_pulse),
        .held             (held)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: prescaler phase, plus per channel whether it is pressed and how
    // many whole ticks have elapsed since the press.
    int mdl_presc;
    bit mdl_prev   [WIDTH];
    bit mdl_active [WIDTH];
    int mdl_ticks  [WIDTH];

    // Observed event statistics (stamp = cycle after which the pulse is visible).
    int press_n [WIDTH], release_n [WIDTH], long_n [WIDTH], repeat_n [WIDTH], held_n [WIDTH];
    int press_at [WIDTH], release_at [WIDTH], long_at [WIDTH], last_lr [WIDTH];
    int gap_bad;
    int rst_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic r, input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] e_press, e_rel, e_long, e_rep, e_held;
        bit tk;
        @(negedge clk);
        rst              = r;
        debounced_signal = s;
        @(posedge clk);
        #1;
        cyc++;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_held = '0;
        if (r) begin
            mdl_presc = 0;
            rst_cyc   = cyc;
            for (int c = 0; c < WIDTH; c++) begin
                mdl_prev[c] = 0; mdl_active[c] = 0; mdl_ticks[c] = 0;
            end
        end else begin
            tk        = (mdl_presc == TICK_CNT_MAX - 1);
            mdl_presc = (mdl_presc + 1) % TICK_CNT_MAX;
            for (int c = 0; c < WIDTH; c++) begin
                bit rise, fall;
                rise = s[c] && !mdl_prev[c];
                fall = !s[c] && mdl_prev[c];
                if (!mdl_active[c]) begin
                    if (rise) begin
                        mdl_active[c] = 1; mdl_ticks[c] = 0; e_press[c] = 1'b1;
                    end
                end else if (fall) begin
                    mdl_active[c] = 0; e_rel[c] = 1'b1;
                end else if (tk) begin
                    mdl_ticks[c]++;
                    if (mdl_ticks[c] == LONG_TICKS) e_long[c] = 1'b1;
                    else if (mdl_ticks[c] > LONG_TICKS &&
                             (mdl_ticks[c] - LONG_TICKS) % REPEAT_TICKS == 0) e_rep[c] = 1'b1;
                end
                mdl_prev[c] = s[c];
                e_held[c]   = mdl_active[c];
            end
        end
        check("outputs", 32'({press_pulse, release_pulse, long_pulse, repeat_pulse, held}),
                         32'({e_press, e_rel, e_long, e_rep, e_held}));
        for (int c = 0; c < WIDTH; c++) begin
            if (press_pulse[c])   begin press_n[c]++;   press_at[c]   = cyc; end
            if (release_pulse[c]) begin release_n[c]++; release_at[c] = cyc; end
            if (long_pulse[c])    begin long_n[c]++;    long_at[c]    = cyc; last_lr[c] = cyc; end
            if (repeat_pulse[c]) begin
                repeat_n[c]++;
                if (cyc - last_lr[c] != REPEAT_TICKS * TICK_CNT_MAX) gap_bad++;
                last_lr[c] = cyc;
            end
            if (held[c]) held_n[c]++;
        end
    endtask

    task automatic run(input int n, input logic r, input logic [WIDTH-1:0] s);
        for (int i = 0; i < n; i++) step(r, s);
    endtask

    // Idle until the next sampled edge sees the prescaler's last count.
    task automatic align_to_tick();
        for (int i = 0; i < 2 * TICK_CNT_MAX && mdl_presc != TICK_CNT_MAX - 1; i++) step(1'b0, '0);
    endtask

    initial begin
        int p0, r0, l0, rp0, h0, g0, p1, r1, l1;
        logic [WIDTH-1:0] s;
        rst = 1'b1;
        debounced_signal = '0;
        mdl_presc = 0;
        gap_bad = 0;
        rst_cyc = 0;
        for (int c = 0; c < WIDTH; c++) begin
            mdl_prev[c] = 0; mdl_active[c] = 0; mdl_ticks[c] = 0;
            press_n[c] = 0; release_n[c] = 0; long_n[c] = 0; repeat_n[c] = 0; held_n[c] = 0;
            press_at[c] = 0; release_at[c] = 0; long_at[c] = 0; last_lr[c] = 0;
        end

        // Reset, then idle: nothing may fire.
        run(3, 1'b1, '0);
        run(20, 1'b0, '0);
        check("idle_events", 32'(press_n[0] + press_n[1] + release_n[0] + release_n[1] +
                                 long_n[0] + long_n[1] + repeat_n[0] + repeat_n[1]), 32'd0);
        check("idle_held", 32'(held_n[0] + held_n[1]), 32'd0);

        // Short press of 6 cycles.
        p0 = press_n[0]; r0 = release_n[0]; l0 = long_n[0]; h0 = held_n[0];
        run(6, 1'b0, 2'b01);
        run(3, 1'b0, 2'b00);
        check("short_press_n", 32'(press_n[0] - p0), 32'd1);
        check("short_release_n", 32'(release_n[0] - r0), 32'd1);
        check("short_no_long", 32'(long_n[0] - l0), 32'd0);
        check("short_rel_delay", 32'(release_at[0] - press_at[0]), 32'd6);
        check("short_held_cycles", 32'(held_n[0] - h0), 32'd6);

        // 40-cycle hold: long then a steady repeat train.
        p0 = press_n[0]; r0 = release_n[0]; l0 = long_n[0]; rp0 = repeat_n[0]; g0 = gap_bad;
        run(40, 1'b0, 2'b01);
        run(4, 1'b0, 2'b00);
        check("hold_press_n", 32'(press_n[0] - p0), 32'd1);
        check("hold_release_n", 32'(release_n[0] - r0), 32'd1);
        check("hold_long_n", 32'(long_n[0] - l0), 32'd1);
        check("hold_long_window", 32'((long_at[0] - press_at[0]) >= 9 &&
                                      (long_at[0] - press_at[0]) <= 12), 32'd1);
        check("hold_repeat_n", 32'(repeat_n[0] - rp0), 32'd3);
        check("hold_repeat_gaps", 32'(gap_bad - g0), 32'd0);

        // Fall on the third tick in SHORT: release wins, then a fresh count.
        align_to_tick();
        r0 = release_n[0]; l0 = long_n[0];
        run(12, 1'b0, 2'b01);
        run(1, 1'b0, 2'b00);
        check("race_release", 32'(release_n[0] - r0), 32'd1);
        check("race_no_long", 32'(long_n[0] - l0), 32'd0);
        run(2, 1'b0, 2'b00);
        align_to_tick();
        l0 = long_n[0];
        run(13, 1'b0, 2'b01);
        run(2, 1'b0, 2'b00);
        check("restart_long_n", 32'(long_n[0] - l0), 32'd1);
        check("restart_long_at", 32'(long_at[0] - press_at[0]), 32'd12);

        // Two channels pressed two cycles apart.
        p0 = press_n[0]; p1 = press_n[1]; l0 = long_n[0]; l1 = long_n[1];
        r0 = release_n[0]; r1 = release_n[1];
        run(2, 1'b0, 2'b01);
        run(30, 1'b0, 2'b11);
        run(3, 1'b0, 2'b00);
        check("dual_press_n0", 32'(press_n[0] - p0), 32'd1);
        check("dual_press_n1", 32'(press_n[1] - p1), 32'd1);
        check("dual_press_gap", 32'(press_at[1] - press_at[0]), 32'd2);
        check("dual_long_n0", 32'(long_n[0] - l0), 32'd1);
        check("dual_long_n1", 32'(long_n[1] - l1), 32'd1);
        check("dual_long1_window", 32'((long_at[1] - press_at[1]) >= 9 &&
                                       (long_at[1] - press_at[1]) <= 12), 32'd1);
        check("dual_release_n0", 32'(release_n[0] - r0), 32'd1);
        check("dual_release_n1", 32'(release_n[1] - r1), 32'd1);

        // Reset while long-held: no release, re-press right after reset.
        p0 = press_n[0]; r0 = release_n[0]; l0 = long_n[0];
        run(16, 1'b0, 2'b01);
        check("rst_long_reached", 32'(long_n[0] - l0), 32'd1);
        run(1, 1'b1, 2'b01);
        check("rst_no_release", 32'(release_n[0] - r0), 32'd0);
        run(20, 1'b0, 2'b01);
        run(3, 1'b0, 2'b00);
        check("rst_press_n", 32'(press_n[0] - p0), 32'd2);
        check("rst_repress_delay", 32'(press_at[0] - rst_cyc), 32'd1);
        check("rst_long_restart", 32'(long_at[0] - press_at[0]), 32'd11);
        check("rst_release_n", 32'(release_n[0] - r0), 32'd1);

        // Random soak against the model.
        s = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < WIDTH; c++)
                if ($urandom_range(11, 0) == 0) s[c] = ~s[c];
            step(($urandom_range(299, 0) == 0), s);
        end
        run(3, 1'b0, '0);
        check("soak_repeat_gaps", 32'(gap_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
